// File: rtl/cai_submit_arbiter.sv
// Round-robin sharing of the single CAI submit doorbell among NREQ requesters.
// Completions are routed back to their owners through a grant-order FIFO.
module cai_submit_arbiter #(
    parameter int NREQ         = 2,
    parameter int PEND_W       = 4,
    parameter int MAX_INFLIGHT = 4,
    localparam int SEL_W       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1),
    localparam int PTR_W       = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_doorbell,
    input  logic                     dev_ready,
    input  logic                     dev_comp_msg,
    output logic                     dev_submit_doorbell,
    output logic [SEL_W-1:0]         dev_submit_sel,
    output logic [NREQ-1:0]          req_comp_pulse,
    output logic [NREQ*PEND_W-1:0]   req_pending,
    output logic [CNT_W-1:0]         inflight_count,
    output logic                     overflow_err,
    output logic                     spurious_comp_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    state_t             r_state;
    state_t             w_next_state;
    logic [PEND_W-1:0]  r_pend [NREQ];
    logic [NREQ-1:0]    w_nonzero;
    logic [NREQ-1:0]    w_dec;
    logic [SEL_W-1:0]   w_grant;
    logic [SEL_W-1:0]   w_grant_hi;
    logic [SEL_W-1:0]   w_grant_lo;
    logic               w_found_hi;
    logic               w_start;
    logic               w_push;
    logic               w_pop;
    logic               w_comp_edge;
    logic [SEL_W-1:0]   r_grant;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic               r_doorbell;
    logic               r_comp_d1;
    logic               r_comp_d2;
    logic [SEL_W-1:0]   r_fifo [MAX_INFLIGHT];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [NREQ-1:0]    r_comp_pulse;
    logic               r_overflow;
    logic               r_spurious;

    function automatic logic [PTR_W-1:0] fifo_next(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(MAX_INFLIGHT - 1)) begin
            n = PTR_W'(0);
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Per-requester pending flags and the decrement strobe for the granted one
    always_comb begin
        w_nonzero = {NREQ{1'b0}};
        w_dec     = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            w_nonzero[i] = (r_pend[i] != PEND_W'(0));
            w_dec[i]     = w_push && (r_grant == SEL_W'(i));
        end
    end

    // Round-robin pick: lowest pending index at/after the pointer, else lowest overall
    always_comb begin
        w_found_hi = 1'b0;
        w_grant_hi = SEL_W'(0);
        w_grant_lo = SEL_W'(0);
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_grant_lo = w_nonzero[i] ? SEL_W'(i) : w_grant_lo;
            w_grant_hi = (w_nonzero[i] && (SEL_W'(i) >= r_rr_ptr)) ? SEL_W'(i) : w_grant_hi;
            w_found_hi = (w_nonzero[i] && (SEL_W'(i) >= r_rr_ptr)) ? 1'b1 : w_found_hi;
        end
        w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
    end

    // Next-state logic; admission is only evaluated while idle
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|w_nonzero) && dev_ready && (r_count < CNT_W'(MAX_INFLIGHT))) begin
                    w_next_state = ST_ISSUE;
                    w_start      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ISSUE: w_next_state = ST_GAP;
            ST_GAP:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    assign w_push      = (r_state == ST_ISSUE);
    assign w_comp_edge = r_comp_d1 & ~r_comp_d2;
    assign w_pop       = w_comp_edge && (r_count != CNT_W'(0));

    // FSM state, doorbell, grant and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_doorbell <= 1'b0;
            r_grant    <= SEL_W'(0);
            r_rr_ptr   <= SEL_W'(0);
        end else begin
            r_state    <= w_next_state;
            r_doorbell <= w_start;
            if (w_start) begin
                r_grant <= w_grant;
            end
            if (w_push) begin
                r_rr_ptr <= (r_grant == SEL_W'(NREQ - 1)) ? SEL_W'(0) : r_grant + SEL_W'(1);
            end
        end
    end

    // Saturating pending counters with sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                r_pend[i] <= PEND_W'(0);
            end
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_doorbell[i] && !w_dec[i]) begin
                    if (r_pend[i] == PEND_MAX) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_pend[i] <= r_pend[i] + PEND_W'(1);
                    end
                end else if (!req_doorbell[i] && w_dec[i]) begin
                    r_pend[i] <= r_pend[i] - PEND_W'(1);
                end
            end
        end
    end

    // Completion edge detector, owner FIFO, in-flight count and routed pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_comp_d1    <= 1'b0;
            r_comp_d2    <= 1'b0;
            r_wr_ptr     <= PTR_W'(0);
            r_rd_ptr     <= PTR_W'(0);
            r_count      <= CNT_W'(0);
            r_comp_pulse <= {NREQ{1'b0}};
            r_spurious   <= 1'b0;
            for (int k = 0; k < MAX_INFLIGHT; k++) begin
                r_fifo[k] <= SEL_W'(0);
            end
        end else begin
            r_comp_d1 <= dev_comp_msg;
            r_comp_d2 <= r_comp_d1;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_grant;
                r_wr_ptr         <= fifo_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= fifo_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            for (int i = 0; i < NREQ; i++) begin
                r_comp_pulse[i] <= w_pop && (r_fifo[r_rd_ptr] == SEL_W'(i));
            end
            if (w_comp_edge && (r_count == CNT_W'(0))) begin
                r_spurious <= 1'b1;
            end
        end
    end

    genvar g;
    for (g = 0; g < NREQ; g++) begin : g_pend_out
        assign req_pending[g*PEND_W +: PEND_W] = r_pend[g];
    end

    assign dev_submit_doorbell = r_doorbell;
    assign dev_submit_sel      = r_grant;
    assign req_comp_pulse      = r_comp_pulse;
    assign inflight_count      = r_count;
    assign overflow_err        = r_overflow;
    assign spurious_comp_err   = r_spurious;

endmodule

// File: tb/tb_cai_submit_arbiter.sv
// Directed self-checking bench for cai_submit_arbiter (NREQ=2, PEND_W=4, MAX_INFLIGHT=4).
module tb_cai_submit_arbiter;

    localparam int NREQ   = 2;
    localparam int PEND_W = 4;
    localparam int MAXI   = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_doorbell;
    logic                   dev_ready;
    logic                   dev_comp_msg;
    logic                   dev_submit_doorbell;
    logic [0:0]             dev_submit_sel;
    logic [NREQ-1:0]        req_comp_pulse;
    logic [NREQ*PEND_W-1:0] req_pending;
    logic [2:0]             inflight_count;
    logic                   overflow_err;
    logic                   spurious_comp_err;

    int checks = 0;
    int errors = 0;

    cai_submit_arbiter #(
        .NREQ(NREQ), .PEND_W(PEND_W), .MAX_INFLIGHT(MAXI)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_doorbell        (req_doorbell),
        .dev_ready           (dev_ready),
        .dev_comp_msg        (dev_comp_msg),
        .dev_submit_doorbell (dev_submit_doorbell),
        .dev_submit_sel      (dev_submit_sel),
        .req_comp_pulse      (req_comp_pulse),
        .req_pending         (req_pending),
        .inflight_count      (inflight_count),
        .overflow_err        (overflow_err),
        .spurious_comp_err   (spurious_comp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 32'({dev_submit_doorbell, dev_submit_sel, req_comp_pulse, req_pending,
                      inflight_count, overflow_err, spurious_comp_err}), 32'd0);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        req_doorbell = 2'b00;
        dev_comp_msg = 1'b0;
        dev_ready    = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int n_iss;
        int n_cmp;
        int last;
        int first;

        do_reset();
        chk_zero("reset_state");

        // Single requester: issue two cycles after the doorbell, completion two after the edge
        req_doorbell = 2'b01;
        tick();
        req_doorbell = 2'b00;
        chk("t1_pend_visible", req_pending, 32'h01);
        chk("t1_no_db_yet", dev_submit_doorbell, 32'd0);
        tick();
        chk("t1_db", dev_submit_doorbell, 32'd1);
        chk("t1_sel", dev_submit_sel, 32'd0);
        tick();
        chk("t1_gap_db_low", dev_submit_doorbell, 32'd0);
        chk("t1_inflight", inflight_count, 32'd1);
        chk("t1_pend_zero", req_pending, 32'h00);
        dev_comp_msg = 1'b1;
        tick();
        dev_comp_msg = 1'b0;
        chk("t1_pulse_early", req_comp_pulse, 32'd0);
        tick();
        chk("t1_pulse", req_comp_pulse, 32'h1);
        chk("t1_inflight_back", inflight_count, 32'd0);
        tick();
        chk("t1_pulse_single", req_comp_pulse, 32'd0);

        // Fairness: both requesters ring three times together; each issue is completed right away
        do_reset();
        chk_zero("reset_state_2");
        n_iss = 0;
        n_cmp = 0;
        last  = 0;
        for (int c = 0; c < 30; c++) begin
            req_doorbell = (c < 3) ? 2'b11 : 2'b00;
            dev_comp_msg = dev_submit_doorbell;
            if (dev_submit_doorbell) begin
                chk("t2_sel_order", 32'(dev_submit_sel), 32'(n_iss % 2));
                if (n_iss > 0) chk("t2_spacing", 32'(c - last), 32'd3);
                last = c;
                n_iss++;
            end
            if (req_comp_pulse != 2'b00) begin
                chk("t2_route", 32'(req_comp_pulse), (n_cmp % 2 == 0) ? 32'h1 : 32'h2);
                n_cmp++;
            end
            tick();
        end
        req_doorbell = 2'b00;
        dev_comp_msg = 1'b0;
        chk("t2_issue_count", 32'(n_iss), 32'd6);
        chk("t2_comp_count", 32'(n_cmp), 32'd6);
        chk("t2_inflight", inflight_count, 32'd0);
        chk("t2_pend", req_pending, 32'h00);

        // In-flight cap: six rings on requester 1 with no completions
        n_iss = 0;
        for (int c = 0; c < 30; c++) begin
            req_doorbell = (c < 6) ? 2'b10 : 2'b00;
            if (dev_submit_doorbell) n_iss++;
            tick();
        end
        req_doorbell = 2'b00;
        chk("t3_issue_count", 32'(n_iss), 32'd4);
        chk("t3_inflight_cap", inflight_count, 32'd4);
        chk("t3_pend_held", req_pending, 32'h20);
        n_iss = 0;
        for (int c = 0; c < 5; c++) begin
            if (dev_submit_doorbell) n_iss++;
            tick();
        end
        chk("t3_blocked", 32'(n_iss), 32'd0);
        first = -1;
        for (int c = 0; c < 6; c++) begin
            dev_comp_msg = (c == 0);
            if (dev_submit_doorbell && first < 0) first = c;
            if (c == 2) chk("t3_pulse_owner", req_comp_pulse, 32'h2);
            tick();
        end
        chk("t3_reissue_delay", 32'(first), 32'd3);
        chk("t3_inflight_refill", inflight_count, 32'd4);
        chk("t3_pend_after", req_pending, 32'h10);

        // Saturation with dev_ready low, then a spurious completion
        do_reset();
        dev_ready = 1'b0;
        n_iss = 0;
        for (int c = 0; c < 16; c++) begin
            req_doorbell = 2'b01;
            if (dev_submit_doorbell) n_iss++;
            if (c == 15) begin
                chk("t4_pend_15", req_pending, 32'h0F);
                chk("t4_no_ovf_yet", overflow_err, 32'd0);
            end
            tick();
        end
        req_doorbell = 2'b00;
        chk("t4_pend_sat", req_pending, 32'h0F);
        chk("t4_overflow", overflow_err, 32'd1);
        chk("t4_no_issue_not_ready", 32'(n_iss), 32'd0);
        dev_comp_msg = 1'b1;
        tick();
        dev_comp_msg = 1'b0;
        n_cmp = 0;
        for (int c = 0; c < 3; c++) begin
            if (req_comp_pulse != 2'b00) n_cmp++;
            tick();
        end
        chk("t4_no_pulse", 32'(n_cmp), 32'd0);
        chk("t4_spurious", spurious_comp_err, 32'd1);
        chk("t4_inflight", inflight_count, 32'd0);
        chk("t4_overflow_sticky", overflow_err, 32'd1);

        // Completion edge coincident with an ISSUE cycle
        do_reset();
        req_doorbell = 2'b01;
        tick();
        req_doorbell = 2'b00;
        tick();
        chk("t5_db0", dev_submit_doorbell, 32'd1);
        req_doorbell = 2'b10;
        tick();
        req_doorbell = 2'b00;
        tick();
        dev_comp_msg = 1'b1;
        tick();
        dev_comp_msg = 1'b0;
        chk("t5_db1", dev_submit_doorbell, 32'd1);
        chk("t5_sel1", dev_submit_sel, 32'd1);
        chk("t5_inflight_pre", inflight_count, 32'd1);
        tick();
        chk("t5_pulse_owner0", req_comp_pulse, 32'h1);
        chk("t5_inflight_same", inflight_count, 32'd1);
        tick();
        dev_comp_msg = 1'b1;
        tick();
        dev_comp_msg = 1'b0;
        tick();
        chk("t5_pulse_owner1", req_comp_pulse, 32'h2);
        chk("t5_inflight_zero", inflight_count, 32'd0);

        // Asynchronous reset in the middle of an ISSUE cycle
        req_doorbell = 2'b01;
        tick();
        req_doorbell = 2'b00;
        tick();
        chk("t5_pre_rst_db", dev_submit_doorbell, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t5_async_reset");
        tick();
        rst_n = 1'b1;
        n_iss = 0;
        for (int c = 0; c < 10; c++) begin
            if (dev_submit_doorbell) n_iss++;
            tick();
        end
        chk("t5_quiet_after_rst", 32'(n_iss), 32'd0);
        req_doorbell = 2'b01;
        tick();
        req_doorbell = 2'b00;
        tick();
        chk("t5_new_db", dev_submit_doorbell, 32'd1);
        chk("t5_new_sel", dev_submit_sel, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
